// File: rtl/hk_wb_pkg.sv
// rtl/hk_wb_pkg.sv - shared widths, defaults and FSM state type for the housekeeping Wishbone arbiter
package hk_wb_pkg;
  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  localparam logic [DAT_W-1:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;
endpackage

// File: rtl/hk_wb_timeout.sv
// rtl/hk_wb_timeout.sv - per-transfer watchdog with fire strobe and sticky timeout flag
module hk_wb_timeout #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ack,
  input  logic clr,
  output logic fire,
  output logic timeout_o
);
  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  // A real ack in the limit cycle suppresses the fire.
  assign fire = active && !ack && (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (!active || ack || fire)
        cnt <= '0;
      else
        cnt <= cnt + TO_W'(1);
      if (fire)
        timeout_o <= 1'b1;
      else if (clr)
        timeout_o <= 1'b0;
    end
  end
endmodule

// File: rtl/hk_wb_arbiter.sv
// rtl/hk_wb_arbiter.sv - two-master round-robin Wishbone arbiter with cycle lock and watchdog
module hk_wb_arbiter
  import hk_wb_pkg::*;
#(
  parameter int               TIMEOUT      = 255,
  parameter int               TO_W         = $clog2(TIMEOUT + 1),
  parameter logic [DAT_W-1:0] TIMEOUT_DATA = DEFAULT_TIMEOUT_DATA
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic             m0_ack_o,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic             m1_ack_o,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic             s_ack_i,
  input  logic [DAT_W-1:0] s_dat_i,
  output logic [1:0]       grant_o,
  output logic             timeout_o,
  input  logic             timeout_clr_i
);
  arb_state_t state;
  logic       rr;
  logic       active;
  logic       fire;
  logic       req0;
  logic       req1;

  assign req0 = m0_cyc_i && m0_stb_i;
  assign req1 = m1_cyc_i && m1_stb_i;

  hk_wb_timeout #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timeout (
    .clk       (wb_clk_i),
    .rst_n     (wb_rstn_i),
    .active    (active),
    .ack       (s_ack_i),
    .clr       (timeout_clr_i),
    .fire      (fire),
    .timeout_o (timeout_o)
  );

  always_comb begin
    active   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;
    case (state)
      OWN0: begin
        active   = req0;
        s_cyc_o  = m0_cyc_i && !fire;
        s_stb_o  = m0_stb_i && !fire;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i || fire;
        m0_dat_o = fire ? TIMEOUT_DATA : s_dat_i;
      end
      OWN1: begin
        active   = req1;
        s_cyc_o  = m1_cyc_i && !fire;
        s_stb_o  = m1_stb_i && !fire;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i || fire;
        m1_dat_o = fire ? TIMEOUT_DATA : s_dat_i;
      end
      default: ;
    endcase
  end

  // rr = 0 prefers master 0 on a tie; every release or forced termination hands preference over.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state   <= IDLE;
      rr      <= 1'b0;
      grant_o <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && (!req1 || !rr)) begin
            state   <= OWN0;
            grant_o <= 2'b01;
          end else if (req1) begin
            state   <= OWN1;
            grant_o <= 2'b10;
          end
        end
        OWN0: begin
          if (!m0_cyc_i || fire) begin
            state   <= IDLE;
            rr      <= 1'b1;
            grant_o <= 2'b00;
          end
        end
        OWN1: begin
          if (!m1_cyc_i || fire) begin
            state   <= IDLE;
            rr      <= 1'b0;
            grant_o <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hk_wb_arbiter.sv
// tb/tb_hk_wb_arbiter.sv - self-checking bench for hk_wb_arbiter with TIMEOUT=8
module tb_hk_wb_arbiter;
  localparam int TO = 8;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m0_ack;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_wdat, m0_rdat;
  logic        m1_cyc, m1_stb, m1_we, m1_ack;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_wdat, m1_rdat;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [1:0]  grant;
  logic        timeout_flag, timeout_clr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          m;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        ack;
    logic [31:0] rdat;
  } vec_t;
  vec_t vecs[4];

  hk_wb_arbiter #(.TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_ack_o(m0_ack), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_ack_o(m1_ack), .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .grant_o(grant), .timeout_o(timeout_flag), .timeout_clr_i(timeout_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input int m, input logic [31:0] act);
    logic [31:0] e;
    int          em;
    checks++;
    e  = 32'h0;
    em = -1;
    if (sb.size() != 0) begin
      e  = sb[0].d;
      em = sb[0].m;
      void'(sb.pop_front());
    end
    if (em != m || act !== e) begin
      failures++;
      $display("FAIL sb_ack_m%0d actual=%h required=%h (expected master %0d)", m, act, e, em);
    end
  endtask

  task automatic observe();
    if (m0_ack) pop_cmp(0, m0_rdat);
    if (m1_ack) pop_cmp(1, m1_rdat);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
    observe();
  endtask

  task automatic m_set(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_wdat = dat; m0_sel = sel;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_wdat = dat; m1_sel = sel;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_set(0, 0, 0, 0, 0, 0, 0);
    m_set(1, 0, 0, 0, 0, 0, 0);
    s_ack = 1'b0; s_rdat = '0; timeout_clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic slave_ack(input int m, input logic [31:0] d);
    s_ack  = 1'b1;
    s_rdat = d;
    sb.push_back('{m, d});
    settle();
    chk("ack_consumed", 32'(sb.size()), 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'hF, 32'h2610_0004, 32'h1111_2222, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 4'h3, 32'h2610_0008, 32'h3333_4444, 1'b1, 32'h0000_0000};
    vecs[2] = '{1'b0, 4'hC, 32'h2610_000C, 32'h0,         1'b0, 32'h0};
    vecs[3] = '{1'b0, 4'h1, 32'h2610_0010, 32'h0,         1'b1, 32'hCAFE_0001};

    // Reset state
    do_reset();
    settle();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_s_cyc", 32'(s_cyc), 0);
    chk("rst_s_stb", 32'(s_stb), 0);
    chk("rst_acks", {30'b0, m1_ack, m0_ack}, 0);
    chk("rst_m0_dat", m0_rdat, 0);
    chk("rst_timeout", 32'(timeout_flag), 0);

    // Single master read, ack on the third owned cycle
    m_set(0, 1, 1, 0, 32'h2610_0000, 0, 4'hF);
    settle();
    chk("t1_latency_stb", 32'(s_stb), 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        slave_ack(0, 32'h1234_5678);
      end else begin
        settle();
        chk("t1_s_stb", 32'(s_stb), 1);
        chk("t1_s_adr", s_adr, 32'h2610_0000);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_no_early_ack", 32'(m0_ack), 0);
      end
      tick();
    end
    s_ack = 1'b0;
    m_set(0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("t1_grant_exit", 32'(grant), 32'h1);
    tick();
    settle();
    chk("t1_grant_idle", 32'(grant), 0);

    // Table-driven mux check while m0 owns and m1 drives different values
    do_reset();
    m_set(0, 1, 1, 0, 32'h2610_0000, 0, 4'hF);
    tick();
    for (int i = 0; i < 4; i++) begin
      m_set(0, 1, 1, vecs[i].we, vecs[i].adr, vecs[i].wdat, vecs[i].sel);
      m_set(1, 1, 1, ~vecs[i].we, ~vecs[i].adr, ~vecs[i].wdat, ~vecs[i].sel);
      if (vecs[i].ack) begin
        slave_ack(0, vecs[i].rdat);
      end else begin
        s_ack = 1'b0;
        settle();
        chk("vec_no_ack", 32'(m0_ack), 0);
      end
      chk("vec_s_we", 32'(s_we), 32'(vecs[i].we));
      chk("vec_s_sel", 32'(s_sel), 32'(vecs[i].sel));
      chk("vec_s_adr", s_adr, vecs[i].adr);
      chk("vec_s_dat", s_wdat, vecs[i].wdat);
      chk("vec_s_cyc", 32'(s_cyc), 1);
      chk("vec_m1_ack", 32'(m1_ack), 0);
      tick();
    end
    s_ack = 1'b0;

    // Tie after reset: m0 first, then m1, then the next tie goes to m1
    do_reset();
    m_set(0, 1, 1, 0, 32'h2610_0020, 0, 4'hF);
    m_set(1, 1, 1, 0, 32'h2610_0030, 0, 4'hF);
    settle();
    chk("t2_idle", 32'(grant), 0);
    tick();
    chk("t2_m0_first", 32'(grant), 32'h1);
    slave_ack(0, 32'hA0A0_0001);
    chk("t2_m1_no_ack", 32'(m1_ack), 0);
    tick();
    s_ack = 1'b0;
    m_set(0, 0, 0, 0, 0, 0, 0);
    settle();
    tick();
    m_set(0, 1, 1, 0, 32'h2610_0040, 0, 4'hF);
    settle();
    chk("t2_idle_gap", 32'(grant), 0);
    tick();
    chk("t2_m1_granted", 32'(grant), 32'h2);
    chk("t2_s_adr_m1", s_adr, 32'h2610_0030);
    slave_ack(1, 32'hB0B0_0002);
    chk("t2_m0_no_ack", 32'(m0_ack), 0);
    chk("t2_m0_dat_zero", m0_rdat, 0);
    tick();
    s_ack = 1'b0;
    m_set(1, 0, 0, 0, 0, 0, 0);
    settle();
    tick();
    s_ack = 1'b1;
    settle();
    chk("t2_late_ack_ignored", {30'b0, m1_ack, m0_ack}, 0);
    s_ack = 1'b0;
    tick();
    chk("t2_m0_after_m1", 32'(grant), 32'h1);
    m_set(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Bus lock: four back-to-back transfers from m0 while m1 waits
    do_reset();
    m_set(0, 1, 1, 0, 32'h2610_0050, 0, 4'hF);
    m_set(1, 1, 1, 0, 32'h2610_0060, 0, 4'hF);
    tick();
    for (int t = 0; t < 4; t++) begin
      m0_adr = 32'h2610_0050 + 32'(t * 4);
      slave_ack(0, 32'h5000_0000 + 32'(t));
      chk("t3_s_cyc_held", 32'(s_cyc), 1);
      chk("t3_grant_locked", 32'(grant), 32'h1);
      tick();
    end
    s_ack = 1'b0;
    m_set(0, 0, 0, 0, 0, 0, 0);
    settle();
    tick();
    chk("t3_idle", 32'(grant), 0);
    tick();
    chk("t3_m1_after_unlock", 32'(grant), 32'h2);
    m_set(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Timeout on an m1 access the slave never acks
    do_reset();
    m_set(1, 1, 1, 0, 32'h2610_0100, 0, 4'hF);
    tick();
    for (int k = 0; k < TO; k++) begin
      if (k == TO - 1) begin
        sb.push_back('{1, TO_DATA});
        settle();
        chk("t4_fire_consumed", 32'(sb.size()), 0);
        chk("t4_s_cyc_cut", 32'(s_cyc), 0);
        chk("t4_s_stb_cut", 32'(s_stb), 0);
        chk("t4_flag_not_yet", 32'(timeout_flag), 0);
      end else begin
        settle();
        chk("t4_wait_no_ack", 32'(m1_ack), 0);
        chk("t4_wait_stb", 32'(s_stb), 1);
      end
      tick();
    end
    m_set(1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("t4_flag_set", 32'(timeout_flag), 1);
    chk("t4_grant_idle", 32'(grant), 0);

    // m0 hangs too; clear asserted in its fire cycle loses, and m1 is not starved
    m_set(0, 1, 1, 0, 32'h2610_0200, 0, 4'hF);
    m_set(1, 1, 1, 0, 32'h2610_0300, 0, 4'hF);
    tick();
    chk("t5_m0_granted", 32'(grant), 32'h1);
    for (int k = 0; k < TO; k++) begin
      if (k == TO - 1) begin
        timeout_clr = 1'b1;
        sb.push_back('{0, TO_DATA});
      end
      settle();
      tick();
    end
    timeout_clr = 1'b0;
    settle();
    chk("t5_set_wins", 32'(timeout_flag), 1);
    chk("t5_pending", 32'(sb.size()), 0);
    tick();
    chk("t5_no_starve", 32'(grant), 32'h2);
    m_set(0, 0, 0, 0, 0, 0, 0);
    m_set(1, 0, 0, 0, 0, 0, 0);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    settle();
    chk("t5_flag_cleared", 32'(timeout_flag), 0);
    tick();

    // Real ack exactly in the limit cycle wins over the timeout
    do_reset();
    m_set(0, 1, 1, 0, 32'h2610_0400, 0, 4'hF);
    tick();
    for (int k = 0; k < TO; k++) begin
      if (k == TO - 1) slave_ack(0, 32'h55AA_1234);
      else settle();
      tick();
    end
    s_ack = 1'b0;
    settle();
    chk("t6_no_flag", 32'(timeout_flag), 0);
    chk("t6_still_owned", 32'(grant), 32'h1);

    // Asynchronous reset mid-transfer
    do_reset();
    m_set(0, 1, 1, 0, 32'h2610_0500, 0, 4'hF);
    tick();
    settle();
    chk("t7_pending_stb", 32'(s_stb), 1);
    rst_n = 1'b0;
    #1;
    s_ack = 1'b1;
    s_rdat = 32'h7777_7777;
    #1;
    chk("t7_s_cyc", 32'(s_cyc), 0);
    chk("t7_s_stb", 32'(s_stb), 0);
    chk("t7_s_adr", s_adr, 0);
    chk("t7_acks", {30'b0, m1_ack, m0_ack}, 0);
    chk("t7_grant", 32'(grant), 0);
    s_ack = 1'b0;
    m_set(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    m_set(0, 1, 1, 0, 32'h2610_0600, 0, 4'hF);
    m_set(1, 1, 1, 0, 32'h2610_0700, 0, 4'hF);
    tick();
    chk("t7_tie_m0", 32'(grant), 32'h1);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
